// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared types and helpers for the trace commit queue: the stored
//            event record, memory-size one-hot constants and store-data masking.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

  // Storage widths of a queued event; the queue's XLEN/AW parameters match these.
  localparam int TRACE_XLEN = 32;
  localparam int TRACE_AW   = 7;

  // One-hot access sizes carried on the mem enable buses.
  localparam logic [2:0] MEM_B = 3'b001;
  localparam logic [2:0] MEM_H = 3'b010;
  localparam logic [2:0] MEM_W = 3'b100;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic                  rd_en;
    logic [TRACE_AW-1:0]   rd;
    logic [TRACE_XLEN-1:0] rd_wdata;
    logic                  pend;
    logic [2:0]            mem_wen;
    logic [TRACE_XLEN-1:0] waddr;
    logic [TRACE_XLEN-1:0] wdata;
    logic [TRACE_XLEN-1:0] raddr;
  } trace_evt_t;

  // Keep only the bytes a store actually writes; the smallest size bit wins.
  function automatic logic [TRACE_XLEN-1:0] mask_wdata(input logic [2:0]            wen,
                                                       input logic [TRACE_XLEN-1:0] data);
    logic [TRACE_XLEN-1:0] res;
    res = '0;
    if ((wen & MEM_B) != 3'b000) begin
      res = {{(TRACE_XLEN-8){1'b0}}, data[7:0]};
    end else if ((wen & MEM_H) != 3'b000) begin
      res = {{(TRACE_XLEN-16){1'b0}}, data[15:0]};
    end else if ((wen & MEM_W) != 3'b000) begin
      res = data;
    end
    return res;
  endfunction

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_wb_match.sv
`default_nettype none
// ============================================================================
// Module   : trace_wb_match
// Purpose  : Finds the youngest valid, pending queue entry whose rd equals a
//            late-writeback address. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module trace_wb_match
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = TRACE_AW
) (
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [DEPTH-1:0]          pend_i,
  input  logic [DEPTH-1:0][AW-1:0]  rd_i,
  input  logic [$clog2(DEPTH)-1:0]  head_i,
  input  logic [AW-1:0]             addr_i,
  output logic                      hit_o,
  output logic [$clog2(DEPTH)-1:0]  idx_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    idx   = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (valid_i[idx] && pend_i[idx] && (rd_i[idx] == addr_i)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule : trace_wb_match
`default_nettype wire

// File: rtl/trace_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : trace_commit_queue
// Purpose  : In-order queue of commit events feeding the trace writer. Events
//            whose rd data is still in flight wait for a late writeback, so the
//            writer only ever sees complete records in program order.
// Revision : 1.0 - initial release
// ============================================================================
module trace_commit_queue
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = TRACE_AW,
  parameter int XLEN  = TRACE_XLEN
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            in_pc_i,
  input  logic                       in_rd_en_i,
  input  logic [AW-1:0]              in_rd_addr_i,
  input  logic [XLEN-1:0]            in_rd_wdata_i,
  input  logic                       in_rd_pend_i,
  input  logic [2:0]                 in_mem_wen_i,
  input  logic [XLEN-1:0]            in_mem_waddr_i,
  input  logic [XLEN-1:0]            in_mem_wdata_i,
  input  logic [2:0]                 in_mem_ren_i,
  input  logic [XLEN-1:0]            in_mem_raddr_i,
  input  logic                       wb1_en_i,
  input  logic [AW-1:0]              wb1_addr_i,
  input  logic [XLEN-1:0]            wb1_data_i,
  input  logic                       wb2_en_i,
  input  logic [AW-1:0]              wb2_addr_i,
  input  logic [XLEN-1:0]            wb2_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            out_pc_o,
  output logic                       out_rd_en_o,
  output logic [AW-1:0]              out_rd_addr_o,
  output logic [XLEN-1:0]            out_rd_wdata_o,
  output logic [2:0]                 out_mem_wen_o,
  output logic [XLEN-1:0]            out_mem_waddr_o,
  output logic [XLEN-1:0]            out_mem_wdata_o,
  output logic [XLEN-1:0]            out_mem_raddr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                inst_count_o,
  output logic                       orphan_wb_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  trace_evt_t                mem_q [DEPTH];
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic [31:0]               inst_q, inst_d;
  logic                      orphan_q, orphan_d;

  trace_evt_t                new_evt, head_evt;
  logic                      vrd, push, pop;
  logic [DEPTH-1:0]          ent_valid, ent_pend;
  logic [DEPTH-1:0][AW-1:0]  ent_rd;
  logic [PW-1:0]             age;
  logic                      wb1_srch, wb2_srch, wb1_hit, wb2_hit;
  logic [PW-1:0]             wb1_idx, wb2_idx;

  assign head_evt    = mem_q[head_q];
  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = (count_q != '0) && !head_evt.pend;
  assign vrd         = in_rd_en_i && (in_rd_addr_i[4:0] != 5'd0);
  assign push        = in_valid_i && in_ready_o && (vrd || (in_mem_wen_i != 3'b000));
  assign pop         = out_valid_o && out_ready_i;
  assign wb1_srch    = wb1_en_i && (wb1_addr_i[4:0] != 5'd0);
  assign wb2_srch    = wb2_en_i && (wb2_addr_i[4:0] != 5'd0);

  // Build the record to enqueue: zero unused addresses, mask store data,
  // and hold rd data at zero until a pending write is resolved.
  always_comb begin
    new_evt          = '0;
    new_evt.pc       = in_pc_i;
    new_evt.rd_en    = vrd;
    new_evt.rd       = in_rd_addr_i;
    new_evt.pend     = vrd && in_rd_pend_i;
    new_evt.rd_wdata = (vrd && !in_rd_pend_i) ? in_rd_wdata_i : '0;
    new_evt.mem_wen  = in_mem_wen_i;
    new_evt.waddr    = (in_mem_wen_i != 3'b000) ? in_mem_waddr_i : '0;
    new_evt.wdata    = mask_wdata(in_mem_wen_i, in_mem_wdata_i);
    new_evt.raddr    = (in_mem_ren_i != 3'b000) ? in_mem_raddr_i : '0;
  end

  // Per-entry occupancy derived from distance to head, plus pend/rd views for the matchers.
  always_comb begin
    ent_valid = '0;
    ent_pend  = '0;
    ent_rd    = '0;
    age       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age          = PW'(i) - head_q;
      ent_valid[i] = (CW'(age) < count_q);
      ent_pend[i]  = mem_q[i].pend;
      ent_rd[i]    = mem_q[i].rd;
    end
  end

  trace_wb_match #(.DEPTH(DEPTH), .AW(AW)) u_match_wb1 (
    .valid_i (ent_valid),
    .pend_i  (ent_pend),
    .rd_i    (ent_rd),
    .head_i  (head_q),
    .addr_i  (wb1_addr_i),
    .hit_o   (wb1_hit),
    .idx_o   (wb1_idx)
  );

  trace_wb_match #(.DEPTH(DEPTH), .AW(AW)) u_match_wb2 (
    .valid_i (ent_valid),
    .pend_i  (ent_pend),
    .rd_i    (ent_rd),
    .head_i  (head_q),
    .addr_i  (wb2_addr_i),
    .hit_o   (wb2_hit),
    .idx_o   (wb2_idx)
  );

  // Next-state for pointers, occupancy, emitted-event counter and sticky orphan flag.
  always_comb begin
    head_d   = head_q + PW'(pop);
    tail_d   = tail_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    inst_d   = inst_q + 32'(pop);
    orphan_d = orphan_q || (wb1_srch && !wb1_hit) || (wb2_srch && !wb2_hit);
  end

  // State registers and entry storage; wb2 is applied after wb1 so it wins a shared hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      inst_q   <= '0;
      orphan_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].pend <= 1'b0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      inst_q   <= inst_d;
      orphan_q <= orphan_d;
      if (push) begin
        mem_q[tail_q] <= new_evt;
      end
      if (wb1_srch && wb1_hit) begin
        mem_q[wb1_idx].rd_wdata <= wb1_data_i;
        mem_q[wb1_idx].pend     <= 1'b0;
      end
      if (wb2_srch && wb2_hit) begin
        mem_q[wb2_idx].rd_wdata <= wb2_data_i;
        mem_q[wb2_idx].pend     <= 1'b0;
      end
    end
  end

  assign out_pc_o        = head_evt.pc;
  assign out_rd_en_o     = head_evt.rd_en;
  assign out_rd_addr_o   = head_evt.rd;
  assign out_rd_wdata_o  = head_evt.rd_wdata;
  assign out_mem_wen_o   = head_evt.mem_wen;
  assign out_mem_waddr_o = head_evt.waddr;
  assign out_mem_wdata_o = head_evt.wdata;
  assign out_mem_raddr_o = head_evt.raddr;
  assign count_o         = count_q;
  assign inst_count_o    = inst_q;
  assign orphan_wb_o     = orphan_q;

endmodule : trace_commit_queue
`default_nettype wire

// File: tb/tb_trace_commit_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_commit_queue
// Purpose  : Directed self-checking bench for trace_commit_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_commit_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic        in_rd_en_i;
  logic [6:0]  in_rd_addr_i;
  logic [31:0] in_rd_wdata_i;
  logic        in_rd_pend_i;
  logic [2:0]  in_mem_wen_i;
  logic [31:0] in_mem_waddr_i;
  logic [31:0] in_mem_wdata_i;
  logic [2:0]  in_mem_ren_i;
  logic [31:0] in_mem_raddr_i;
  logic        wb1_en_i, wb2_en_i;
  logic [6:0]  wb1_addr_i, wb2_addr_i;
  logic [31:0] wb1_data_i, wb2_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic        out_rd_en_o;
  logic [6:0]  out_rd_addr_o;
  logic [31:0] out_rd_wdata_o;
  logic [2:0]  out_mem_wen_o;
  logic [31:0] out_mem_waddr_o;
  logic [31:0] out_mem_wdata_o;
  logic [31:0] out_mem_raddr_o;
  logic [3:0]  count_o;
  logic [31:0] inst_count_o;
  logic        orphan_wb_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  trace_commit_queue #(.DEPTH(8), .AW(7), .XLEN(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_pc_i         (in_pc_i),
    .in_rd_en_i      (in_rd_en_i),
    .in_rd_addr_i    (in_rd_addr_i),
    .in_rd_wdata_i   (in_rd_wdata_i),
    .in_rd_pend_i    (in_rd_pend_i),
    .in_mem_wen_i    (in_mem_wen_i),
    .in_mem_waddr_i  (in_mem_waddr_i),
    .in_mem_wdata_i  (in_mem_wdata_i),
    .in_mem_ren_i    (in_mem_ren_i),
    .in_mem_raddr_i  (in_mem_raddr_i),
    .wb1_en_i        (wb1_en_i),
    .wb1_addr_i      (wb1_addr_i),
    .wb1_data_i      (wb1_data_i),
    .wb2_en_i        (wb2_en_i),
    .wb2_addr_i      (wb2_addr_i),
    .wb2_data_i      (wb2_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_pc_o        (out_pc_o),
    .out_rd_en_o     (out_rd_en_o),
    .out_rd_addr_o   (out_rd_addr_o),
    .out_rd_wdata_o  (out_rd_wdata_o),
    .out_mem_wen_o   (out_mem_wen_o),
    .out_mem_waddr_o (out_mem_waddr_o),
    .out_mem_wdata_o (out_mem_wdata_o),
    .out_mem_raddr_o (out_mem_raddr_o),
    .count_o         (count_o),
    .inst_count_o    (inst_count_o),
    .orphan_wb_o     (orphan_wb_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic rd_en, input logic [6:0] rd,
                      input logic [31:0] data, input logic pend, input logic [2:0] wen,
                      input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic [2:0] ren, input logic [31:0] raddr);
    in_valid_i     = 1'b1;
    in_pc_i        = pc;
    in_rd_en_i     = rd_en;
    in_rd_addr_i   = rd;
    in_rd_wdata_i  = data;
    in_rd_pend_i   = pend;
    in_mem_wen_i   = wen;
    in_mem_waddr_i = waddr;
    in_mem_wdata_i = wdata;
    in_mem_ren_i   = ren;
    in_mem_raddr_i = raddr;
    tick();
    in_valid_i     = 1'b0;
  endtask

  task automatic push_rd(input logic [31:0] pc, input logic [6:0] rd,
                         input logic [31:0] data, input logic pend);
    push(pc, 1'b1, rd, data, pend, 3'b000, 32'h0, 32'h0, 3'b000, 32'h0);
  endtask

  task automatic wb(input int port, input logic [6:0] addr, input logic [31:0] data);
    if (port == 1) begin
      wb1_en_i = 1'b1; wb1_addr_i = addr; wb1_data_i = data;
    end else begin
      wb2_en_i = 1'b1; wb2_addr_i = addr; wb2_data_i = data;
    end
    tick();
    wb1_en_i = 1'b0;
    wb2_en_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_pc_i = '0; in_rd_en_i = 1'b0; in_rd_addr_i = '0; in_rd_wdata_i = '0; in_rd_pend_i = 1'b0;
    in_mem_wen_i = '0; in_mem_waddr_i = '0; in_mem_wdata_i = '0; in_mem_ren_i = '0; in_mem_raddr_i = '0;
    wb1_en_i = 1'b0; wb1_addr_i = '0; wb1_data_i = '0;
    wb2_en_i = 1'b0; wb2_addr_i = '0; wb2_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    check("rst_count", count_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_inst", inst_count_o, 0);
    check("rst_orphan", orphan_wb_o, 0);

    // Simple ADDI flows straight through
    out_ready_i = 1'b1;
    push_rd(32'h100, 7'd5, 32'h2A, 1'b0);
    check("addi_valid", out_valid_o, 1);
    check("addi_pc", out_pc_o, 32'h100);
    check("addi_rd", out_rd_addr_o, 5);
    check("addi_data", out_rd_wdata_o, 32'h2A);
    check("addi_rden", out_rd_en_o, 1);
    tick();
    check("addi_inst", inst_count_o, 1);
    check("addi_empty", count_o, 0);

    // Pending load blocks the younger ADD until wb1 delivers
    push_rd(32'h104, 7'd10, 32'h0, 1'b1);
    push_rd(32'h108, 7'd11, 32'h7, 1'b0);
    check("ld_count", count_o, 2);
    repeat (5) tick();
    check("ld_blocked", out_valid_o, 0);
    check("ld_count_hold", count_o, 2);
    wb(1, 7'd10, 32'hDEADBEEF);
    check("ld_valid", out_valid_o, 1);
    check("ld_pc", out_pc_o, 32'h104);
    check("ld_data", out_rd_wdata_o, 32'hDEADBEEF);
    tick();
    check("add_pc", out_pc_o, 32'h108);
    check("add_data", out_rd_wdata_o, 32'h7);
    tick();
    check("ld_inst", inst_count_o, 3);

    // Two pending to x6: writeback goes to the youngest only
    push_rd(32'h200, 7'd6, 32'h0, 1'b1);
    push_rd(32'h204, 7'd6, 32'h0, 1'b1);
    wb(2, 7'd6, 32'h11);
    check("young_blocked", out_valid_o, 0);
    check("young_count", count_o, 2);
    wb(1, 7'd6, 32'h22);
    check("old_pc", out_pc_o, 32'h200);
    check("old_data", out_rd_wdata_o, 32'h22);
    tick();
    check("young_pc", out_pc_o, 32'h204);
    check("young_data", out_rd_wdata_o, 32'h11);
    tick();

    // wb1 and wb2 hit the same entry: wb2 wins
    push_rd(32'h210, 7'd8, 32'h0, 1'b1);
    wb1_en_i = 1'b1; wb1_addr_i = 7'd8; wb1_data_i = 32'hAAAA;
    wb(2, 7'd8, 32'hBBBB);
    check("dual_pc", out_pc_o, 32'h210);
    check("dual_data", out_rd_wdata_o, 32'hBBBB);
    tick();

    // Stores/loads: masking and address zeroing
    push(32'h300, 1'b0, 7'd0, 32'h0, 1'b0, 3'b001, 32'h80, 32'h12345678, 3'b000, 32'h999);
    check("sb_pc", out_pc_o, 32'h300);
    check("sb_wdata", out_mem_wdata_o, 32'h78);
    check("sb_rden", out_rd_en_o, 0);
    check("sb_waddr", out_mem_waddr_o, 32'h80);
    check("sb_wen", out_mem_wen_o, 3'b001);
    check("sb_raddr", out_mem_raddr_o, 0);
    push(32'h304, 1'b0, 7'd0, 32'h0, 1'b0, 3'b010, 32'h84, 32'h12345678, 3'b000, 32'h0);
    check("sh_wdata", out_mem_wdata_o, 32'h5678);
    push(32'h308, 1'b1, 7'd9, 32'h5, 1'b0, 3'b000, 32'h88, 32'hFFFF, 3'b100, 32'h440);
    check("lw_raddr", out_mem_raddr_o, 32'h440);
    check("lw_waddr", out_mem_waddr_o, 0);
    check("lw_wdata", out_mem_wdata_o, 0);
    check("lw_data", out_rd_wdata_o, 32'h5);
    tick();
    check("st_inst", inst_count_o, 9);

    // Fill to full, then pop and push together: push refused
    out_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_rd(32'h500 + 32'(4 * i), 7'd1, 32'(i), 1'b0);
    end
    check("full_count", count_o, 8);
    check("full_ready", in_ready_o, 0);
    check("full_head", out_pc_o, 32'h500);
    out_ready_i = 1'b1;
    push_rd(32'h600, 7'd2, 32'h66, 1'b0);
    check("full_pop_count", count_o, 7);
    check("full_pop_ready", in_ready_o, 1);
    check("full_pop_head", out_pc_o, 32'h504);
    repeat (7) tick();
    check("drain_count", count_o, 0);
    check("drain_inst", inst_count_o, 17);

    // Orphan writeback is sticky
    wb(1, 7'd7, 32'h77);
    check("orphan_set", orphan_wb_o, 1);
    repeat (3) tick();
    check("orphan_stay", orphan_wb_o, 1);

    // Events with no valid rd and no store are dropped
    out_ready_i = 1'b0;
    push_rd(32'h700, 7'd0, 32'h5, 1'b0);
    push_rd(32'h704, 7'h20, 32'h5, 1'b0);
    push(32'h708, 1'b0, 7'd3, 32'h5, 1'b0, 3'b000, 32'h0, 32'h0, 3'b100, 32'h10);
    check("drop_count", count_o, 0);
    check("drop_valid", out_valid_o, 0);

    // Reset with three entries queued
    push_rd(32'h800, 7'd3, 32'h1, 1'b0);
    push_rd(32'h804, 7'd3, 32'h2, 1'b1);
    push_rd(32'h808, 7'd4, 32'h3, 1'b0);
    check("pre_rst_count", count_o, 3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_count", count_o, 0);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_orphan", orphan_wb_o, 0);
    check("mid_rst_inst", inst_count_o, 0);

    // Queue works normally after reset
    out_ready_i = 1'b1;
    push_rd(32'h900, 7'd4, 32'h9, 1'b0);
    check("post_rst_pc", out_pc_o, 32'h900);
    check("post_rst_valid", out_valid_o, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_trace_commit_queue
`default_nettype wire

// File: doc/trace_commit_queue.md
Name: trace_commit_queue

Overview:
- Simulation-support block directly upstream of the register-status trace writer.
- Captures per-cycle commit events (pc, rd write, memory access) into an in-order queue.
- Holds events whose rd data is still in flight (loads, mul/div) until a late-writeback port delivers the data, so the writer receives complete records in program order and needs no file patching.
- Emits completed events over a valid/ready handshake.

Parameters:
- DEPTH, 8: queue entries; power of two, at least 2.
- AW, 7: rd address width; the full AW bits are used for matching.
- XLEN, 32: data and address width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  commit event offered.
- in_ready_o  out  1  queue can accept.
- in_pc_i  in  XLEN  committed pc.
- in_rd_en_i  in  1  instruction writes rd.
- in_rd_addr_i  in  AW  rd address.
- in_rd_wdata_i  in  XLEN  rd data; ignored when in_rd_pend_i=1.
- in_rd_pend_i  in  1  rd data arrives later on a wb port.
- in_mem_wen_i  in  3  store size one-hot: [0] byte, [1] half, [2] word.
- in_mem_waddr_i  in  XLEN  store address.
- in_mem_wdata_i  in  XLEN  store data, unmasked.
- in_mem_ren_i  in  3  load size one-hot.
- in_mem_raddr_i  in  XLEN  load address.
- wb1_en_i, wb2_en_i  in  1  late writeback valid.
- wb1_addr_i, wb2_addr_i  in  AW  late writeback rd.
- wb1_data_i, wb2_data_i  in  XLEN  late writeback data.
- out_valid_o  out  1  head event complete and presented.
- out_ready_i  in  1  writer consumes.
- out_pc_o  out  XLEN  event pc.
- out_rd_en_o  out  1  event has a valid rd write.
- out_rd_addr_o  out  AW  event rd.
- out_rd_wdata_o  out  XLEN  final rd data.
- out_mem_wen_o  out  3  store size.
- out_mem_waddr_o  out  XLEN  store address.
- out_mem_wdata_o  out  XLEN  size-masked store data.
- out_mem_raddr_o  out  XLEN  load address.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- inst_count_o  out  32  events emitted.
- orphan_wb_o  out  1  sticky: a wb matched no pending entry.

Behaviour:
- Reset (rst_i=1 at an edge):
  - pointers, count_o, inst_count_o and orphan_wb_o go to 0; all pending bits clear.
  - out_valid_o=0; in_ready_o=1 from the first post-reset cycle.
  - Reset mid-operation discards all entries, including pending ones.
- Accept: the push fires when in_valid_i & in_ready_o.
  - vrd = in_rd_en_i & (in_rd_addr_i[4:0]!=0).
  - The event is enqueued only if vrd | (in_mem_wen_i!=0); other accepted events are dropped silently.
- Capture rules:
  - mem addresses are stored as 0 when the matching enable is 0.
  - wdata is masked by priority wen[0] (8 bits), then wen[1] (16 bits), then wen[2] (32 bits); otherwise 0.
  - pending bit = vrd & in_rd_pend_i; pending entries store rd_wdata=0.
- in_ready_o = (count_o < DEPTH). There is no same-cycle pop-to-push bypass when the queue is full.
- Late writeback:
  - wbN_en_i with wbN_addr_i[4:0]!=0 searches the valid, pending entries for rd==wbN_addr_i (full AW bits).
  - The youngest match is written with wbN_data_i and its pending bit is cleared.
  - The entry being pushed in the same cycle is not searched.
  - If wb1 and wb2 hit the same entry, wb2 data wins.
  - No match sets orphan_wb_o; it stays set until reset.
- Output:
  - out_valid_o = queue not empty & head not pending.
  - A non-pending event accepted at edge N is visible at N+1 if it is at the head.
  - A wb that completes the head at edge N gives out_valid_o=1 at N+1.
  - A pending head blocks all younger entries.
  - Pop fires on out_valid_o & out_ready_i; inst_count_o increments on each pop.
  - Outputs are stable while out_valid_o=1 and out_ready_i=0.
- Push and pop in the same cycle leave count_o unchanged. Pointers wrap modulo DEPTH.

Decomposition:
- Package trace_pkg:
  - trace_evt_t struct: pc, rd_en, rd, rd_wdata, pend, mem_wen, waddr, wdata, raddr.
  - MEM_B/MEM_H/MEM_W one-hot constants.
  - Function mask_wdata(wen, data).
- Sub-module trace_wb_match: combinational youngest-pending-match finder. Inputs are the entry valid/pend/rd vectors, head pointer, and wb address; outputs are hit and index. It is instantiated twice.

Test Plan:
- Reset, then push ADDI pc=0x100, rd=x5, data=0x2A, not pending, with out_ready_i=1 → out_valid_o=1 one cycle after accept with the same fields; inst_count_o=1.
- Push load pc=0x104, rd=x10, pend=1, then ADD pc=0x108, rd=x11, data=7. Hold wb idle 5 cycles → out_valid_o stays 0. Then wb1 x10=0xDEADBEEF → pc 0x104 is emitted with 0xDEADBEEF, followed by 0x108.
- Two pending entries to x6 (pc 0x200, 0x204), then wb2 x6=0x11 → only the 0x204 entry completes; head 0x200 still blocks.
- Store sb pc=0x300, wen=001, wdata=0x12345678, waddr=0x80 → out_mem_wdata_o=0x00000078, out_rd_en_o=0.
- Fill 8 entries with out_ready_i=0 → in_ready_o=0 and count_o=8. Simultaneous pop and push → push refused.
- wb1 to x7 with no pending entry → orphan_wb_o=1 and stays set. Event with rd=x0 and no store → not enqueued. Assert rst_i with 3 entries queued → count_o=0 and out_valid_o=0 next cycle.
